// File: rtl/bcd_pkg.sv
// Shared types and constants for the packed-BCD to binary converter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bcd_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam int DIG_N = 4;
    localparam int ACC_W = 14;

    localparam logic [ACC_W-1:0] W1000 = 14'd1000;
    localparam logic [ACC_W-1:0] W100  = 14'd100;
    localparam logic [ACC_W-1:0] W10   = 14'd10;
    localparam logic [ACC_W-1:0] W1    = 14'd1;

    // Decimal weight of the digit addressed by a pointer value 4..1.
    function automatic logic [ACC_W-1:0] digit_weight(input logic [2:0] ptr);
        case (ptr)
            3'd4:    digit_weight = W1000;
            3'd3:    digit_weight = W100;
            3'd2:    digit_weight = W10;
            3'd1:    digit_weight = W1;
            default: digit_weight = '0;
        endcase
    endfunction

endpackage

// File: rtl/bcd_nibble_check.sv
// Flags a packed-BCD word containing any nibble above 9.
// Latency: combinational.
// Backpressure: none.
module bcd_nibble_check
    import bcd_pkg::*;
(
    input  logic [4*DIG_N-1:0] dec,
    output logic               err
);

    // Any nibble in the range A..F makes the whole word invalid.
    always_comb begin
        err = 1'b0;
        for (int i = 0; i < DIG_N; i++) begin
            if (dec[4*i +: 4] > 4'd9) err = 1'b1;
        end
    end

endmodule

// File: rtl/dec4_to_bin12.sv
// Sequential 4-digit packed-BCD to binary converter by repeated weighted addition; DEC4_BIN_SAT_EN selects saturation on overflow.
// Latency: ok in cycle S+5 after the st edge (S = digit sum), cycle 1 for an invalid digit.
// Backpressure: st is accepted only in IDLE; pulses while busy or in the ok cycle are dropped.
module dec4_to_bin12
    import bcd_pkg::*;
#(
    parameter int OUT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             st,
    input  logic [15:0]      DEC,
    output logic [OUT_W-1:0] BIN,
    output logic [2:0]       ptr_dig,
    output logic             busy,
    output logic             ok,
    output logic             err,
    output logic             ovf
);

    localparam logic [ACC_W-1:0] BIN_MAX = ACC_W'((1 << OUT_W) - 1);

    state_t                 state, state_nxt;
    logic [DIG_N-1:0][3:0]  dig;
    logic [ACC_W-1:0]       acc;
    logic                   dec_bad;
    logic [1:0]             sel;
    logic [3:0]             cur_dig;
    logic                   acc_ovf;
    logic [OUT_W-1:0]       bin_res;

    bcd_nibble_check u_chk (
        .dec (DEC),
        .err (dec_bad)
    );

    // Pointer 4..1 maps to digit index 3..0; result shaping for the final edge.
    always_comb begin
        sel     = ptr_dig[1:0] - 2'd1;
        cur_dig = dig[sel];
        acc_ovf = (acc > BIN_MAX);
`ifdef DEC4_BIN_SAT_EN
        bin_res = acc_ovf ? {OUT_W{1'b1}} : acc[OUT_W-1:0];
`else
        bin_res = acc[OUT_W-1:0];
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next state plus status strobes decoded from the current state.
    always_comb begin
        state_nxt = state;
        busy      = (state != S_IDLE);
        ok        = (state == S_FIN) || (state == S_ERR);
        case (state)
            S_IDLE: if (st) state_nxt = dec_bad ? S_ERR : S_RUN;
            S_RUN:  if (cur_dig == 4'd0 && ptr_dig == 3'd1) state_nxt = S_FIN;
            S_FIN:  state_nxt = S_IDLE;
            S_ERR:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Digit down-counters, pointer, accumulator and held result flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dig     <= '0;
            acc     <= '0;
            ptr_dig <= 3'd0;
            BIN     <= '0;
            err     <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (st) begin
                        dig     <= DEC;
                        acc     <= '0;
                        err     <= dec_bad;
                        ovf     <= 1'b0;
                        // An invalid word completes next cycle, so the pointer never leaves 0.
                        ptr_dig <= dec_bad ? 3'd0 : 3'd4;
                    end
                end
                S_RUN: begin
                    if (cur_dig != 4'd0) begin
                        acc      <= acc + digit_weight(ptr_dig);
                        dig[sel] <= cur_dig - 4'd1;
                    end else if (ptr_dig > 3'd1) begin
                        ptr_dig <= ptr_dig - 3'd1;
                    end else begin
                        ptr_dig <= 3'd0;
                        BIN     <= bin_res;
                        ovf     <= acc_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
